// File: rtl/carpma_sirali.sv
// rtl/carpma_sirali.sv - multi-cycle shift-add multiplier, unsigned or signed per operation
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   basla     start request, taken only while hazir=1
//   isaretli  mode sampled with basla: 1 = two's-complement signed, 0 = unsigned
//   sayi1     multiplicand (W bits), sampled on accept
//   sayi2     multiplier (W bits), sampled on accept
//   hazir     idle, ready to accept basla
//   gecerli   one-cycle pulse, sonuc/tasma carry a fresh result
//   tasma     product does not fit in W bits in the selected mode
//   sonuc     full 2W-bit product, held until the next result or reset
module carpma_sirali #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           basla,
    input  logic           isaretli,
    input  logic [W-1:0]   sayi1,
    input  logic [W-1:0]   sayi2,
    output logic           hazir,
    output logic           gecerli,
    output logic           tasma,
    output logic [2*W-1:0] sonuc
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] SON_ADIM = CW'(W - 1);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        BITIS = 2'd2
    } durum_t;

    durum_t          durum;
    logic [2*W-1:0]  acc;         // upper half: partial sum, lower half: remaining multiplier bits
    logic [W-1:0]    carpilan;    // multiplicand magnitude
    logic [CW-1:0]   sayac;
    logic            isaret_neg;  // final product must be negated
    logic            mod_isaretli;

    logic [W-1:0]    mag1;
    logic [W-1:0]    mag2;
    logic [W:0]      toplam;
    logic [2*W-1:0]  acc_next;
    logic [2*W-1:0]  sonuc_next;
    logic            tasma_next;

    // Signed operands are multiplied as magnitudes; the most negative value
    // maps to 2^(W-1), which still fits the W-bit unsigned magnitude.
    always_comb begin
        mag1 = sayi1;
        mag2 = sayi2;
        if (isaretli && sayi1[W-1]) mag1 = -sayi1;
        if (isaretli && sayi2[W-1]) mag2 = -sayi2;
    end

    // One multiplier bit per step: conditionally add into the upper W+1 bits
    // (keeping the carry) and shift the whole accumulator right by one.
    always_comb begin
        toplam = {1'b0, acc[2*W-1:W]};
        if (acc[0]) toplam = {1'b0, acc[2*W-1:W]} + {1'b0, carpilan};
        acc_next = {toplam, acc[W-1:1]};
    end

    always_comb begin
        sonuc_next = acc;
        if (isaret_neg) sonuc_next = -acc;
        if (mod_isaretli)
            // Signed fits in W bits only if bits 2W-1..W-1 are a pure sign extension.
            tasma_next = ~((&sonuc_next[2*W-1:W-1]) | ~(|sonuc_next[2*W-1:W-1]));
        else
            tasma_next = |sonuc_next[2*W-1:W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum        <= BOS;
            hazir        <= 1'b1;
            gecerli      <= 1'b0;
            tasma        <= 1'b0;
            sonuc        <= '0;
            acc          <= '0;
            carpilan     <= '0;
            sayac        <= '0;
            isaret_neg   <= 1'b0;
            mod_isaretli <= 1'b0;
        end else begin
            gecerli <= 1'b0;
            case (durum)
                BOS: begin
                    if (basla) begin
                        mod_isaretli <= isaretli;
                        carpilan     <= mag1;
                        acc          <= {{W{1'b0}}, mag2};
                        isaret_neg   <= isaretli & (sayi1[W-1] ^ sayi2[W-1]);
                        sayac        <= '0;
                        hazir        <= 1'b0;
                        durum        <= HESAP;
                    end
                end
                HESAP: begin
                    acc   <= acc_next;
                    sayac <= sayac + CW'(1);
                    if (sayac == SON_ADIM) durum <= BITIS;
                end
                BITIS: begin
                    sonuc   <= sonuc_next;
                    tasma   <= tasma_next;
                    gecerli <= 1'b1;
                    hazir   <= 1'b1;
                    durum   <= BOS;
                end
                default: begin
                    hazir <= 1'b1;
                    durum <= BOS;
                end
            endcase
        end
    end

endmodule
